// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream request ports and serial line of the UART transmit arbiter.
// master = the two requesters (bench / SoC side); slave = the arbiter itself.
interface uart_tx_arbiter_if;
    logic [7:0] s0_data;
    logic       s0_valid;
    logic       s0_ready;
    logic [7:0] s1_data;
    logic       s1_valid;
    logic       s1_ready;
    logic       uart_txd;
    logic       busy;
    logic [1:0] grant;
    logic [1:0] state_dbg;

    modport master (
        output s0_data, s0_valid, s1_data, s1_valid,
        input  s0_ready, s1_ready, uart_txd, busy, grant, state_dbg
    );

    modport slave (
        input  s0_data, s0_valid, s1_data, s1_valid,
        output s0_ready, s1_ready, uart_txd, busy, grant, state_dbg
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-port byte arbiter feeding one 8N1 UART transmitter; arbitration is per byte
// with a burst cap so one busy source cannot starve the other.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BURST_MAX    = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Handshake: a byte moves when sK_valid && sK_ready in the same cycle.
    // ready is only offered in IDLE, to the arbitration winner, and only while it is valid.
    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            txd_q;
    logic            busy_q;
    logic [1:0]      grant_q;
    logic            last_owner;
    logic [BW-1:0]   burst_cnt;
    logic            pick;
    logic            handshake;
    logic            baud_last;

    always_comb begin
        pick = bus.s1_valid;
        if (bus.s0_valid && bus.s1_valid)
            pick = (burst_cnt < BURST_LIM) ? last_owner : ~last_owner;
    end

    assign bus.s0_ready  = (state == IDLE) && bus.s0_valid && !pick;
    assign bus.s1_ready  = (state == IDLE) && bus.s1_valid && pick;
    assign handshake     = bus.s0_ready || bus.s1_ready;
    assign baud_last     = (baud_cnt == BAUD_LAST);

    assign bus.uart_txd  = txd_q;
    assign bus.busy      = busy_q;
    assign bus.grant     = grant_q;
    assign bus.state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            grant_q    <= 2'b00;
            last_owner <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        shift_reg <= pick ? bus.s1_data : bus.s0_data;
                        grant_q   <= pick ? 2'b10 : 2'b01;
                        busy_q    <= 1'b1;
                        txd_q     <= 1'b0;
                        baud_cnt  <= '0;
                        state     <= START;
                        // Saturating burst count for the repeat owner; a switch restarts it at 1.
                        if (pick == last_owner) begin
                            if (burst_cnt != BURST_LIM)
                                burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            last_owner <= pick;
                            burst_cnt  <= BW'(1);
                        end
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        txd_q    <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            txd_q     <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        busy_q   <= 1'b0;
                        grant_q  <= 2'b00;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
